// File: rtl/data_mem_ctrl_pkg.sv
// Shared types and constants for the data-memory access stage.
package mem_ctrl_pkg;

  // Access sequencing: wait for an instruction, hold the bus, commit.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Default number of REQ cycles tolerated before the access is aborted.
  localparam int unsigned TIMEOUT_DEF = 15;

  // Counter width needed to hold the value `timeout` itself.
  function automatic int unsigned cnt_width(input int unsigned timeout);
    return $clog2(timeout + 1);
  endfunction

  localparam int unsigned CNT_W = cnt_width(TIMEOUT_DEF);

  // Byte-offset bits that must be zero for a word access.
  localparam logic [1:0] ALIGN_MASK = 2'b11;

endpackage

// File: rtl/data_mem_ctrl_if.sv
// Request/acknowledge bus between the access stage and the data RAM.
interface data_mem_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();

  logic              bus_req;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic              bus_ack;
  logic [DATA_W-1:0] bus_rdata;

  // The access stage drives the request side.
  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata,
    input  bus_ack, bus_rdata
  );

  // The RAM answers with a one-cycle ack and its read data.
  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata,
    output bus_ack, bus_rdata
  );

endinterface

// File: rtl/data_mem_ctrl_wait_timer.sv
// Counts REQ cycles; tc flags that the count has reached TIMEOUT.
module wait_timer
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEF,
  parameter int unsigned WIDTH   = cnt_width(TIMEOUT)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [WIDTH-1:0] count;

  // Clear has priority over enable so a finished access always restarts at zero.
  always_ff @(posedge clk) begin
    // NOTE: registers take <= so every flop samples pre-edge values, whatever the statement order.
    if (rst || clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + WIDTH'(1);
    end
  end

  assign tc = (count == WIDTH'(TIMEOUT));

endmodule

// File: rtl/data_mem_ctrl.sv
// Data-memory access stage: turns a load/store from the single-cycle datapath
// into one req/ack transaction on the data RAM bus and stalls the datapath
// until the access completes, aborts on timeout or is rejected as misaligned.
module data_mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int              ADDR_W   = 32,
  parameter int              DATA_W   = 32,
  parameter int unsigned     TIMEOUT  = TIMEOUT_DEF,
  parameter logic [DATA_W-1:0] ERR_DATA = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_write,
  input  logic              mem_read,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              stall,
  output logic              mem_err,
  data_mem_ctrl_if.master   bus
);

  state_t            state_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;     // DONE was entered through a timeout

  logic access;
  logic aligned;
  logic start;
  logic misaligned;
  logic tmr_en;
  logic tmr_clr;
  logic tmr_tc;

  assign access  = mem_read | mem_write;
  assign aligned = (addr[1:0] & ALIGN_MASK) == 2'b00;

  // A new access is only considered in IDLE and never while reset is applied.
  assign start      = !rst && (state_q == IDLE) && access && aligned;
  assign misaligned = !rst && (state_q == IDLE) && access && !aligned;

  // The timer runs from the launch edge through every unacknowledged REQ
  // cycle, so during the k-th REQ cycle it holds k; at TIMEOUT the access aborts.
  assign tmr_en  = start || ((state_q == REQ) && !bus.bus_ack && !tmr_tc);
  assign tmr_clr = !tmr_en;

  wait_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_wait_timer (
    .clk(clk),
    .rst(rst),
    .clr(tmr_clr),
    .en (tmr_en),
    .tc (tmr_tc)
  );

  // Datapath-facing status: stall while launching or waiting, error pulses, read mux.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    stall   = 1'b0;
    mem_err = 1'b0;
    rdata   = rdata_q;
    if (start || (!rst && state_q == REQ)) begin
      stall = 1'b1;
    end
    if (misaligned) begin
      mem_err = 1'b1;
      rdata   = ERR_DATA;
    end else if (!rst && state_q == DONE && err_q) begin
      mem_err = 1'b1;
    end
  end

  // Access sequencer with registered bus outputs and captured read data.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      bus.bus_req   <= 1'b0;
      bus.bus_we    <= 1'b0;
      bus.bus_addr  <= '0;
      bus.bus_wdata <= '0;
      rdata_q       <= '0;
      err_q         <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          // Misaligned accesses and stray acks leave everything untouched.
          if (access && aligned) begin
            bus.bus_addr  <= addr & ~ADDR_W'(ALIGN_MASK);
            bus.bus_wdata <= wdata;
            bus.bus_we    <= mem_write;   // read+write together counts as a write
            bus.bus_req   <= 1'b1;
            err_q         <= 1'b0;
            state_q       <= REQ;
          end
        end
        REQ: begin
          // An ack wins over a timeout landing in the same cycle.
          if (bus.bus_ack) begin
            if (!bus.bus_we) begin
              rdata_q <= bus.bus_rdata;
            end
            bus.bus_req <= 1'b0;
            err_q       <= 1'b0;
            state_q     <= DONE;
          end else if (tmr_tc) begin
            bus.bus_req <= 1'b0;
            rdata_q     <= ERR_DATA;
            err_q       <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          bus.bus_req <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

endmodule
